fetch_pc_gen: RTL and testbench

- Front end of the fetch stage, directly upstream of the branch predictor.
- Owns the architectural fetch PC and forms WAY consecutive PCs per cycle. Drives them to the predictor, consumes its per-slot prediction and target, and truncates the group at the first predicted-taken slot.
- Enqueues surviving instructions, with their prediction metadata, into an internal fetch queue that dispatch drains.
- Handles icache misses and back-end redirects (mispredict or exception flush).

---
 rtl/fetch_pc_gen_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 75 +++++++
 rtl/fetch_pc_gen.sv | 135 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch types: the packet carried from PC generation into the fetch queue,
// the PC-generator FSM states, and default geometry.
package fetch_pc_gen_pkg;

  localparam int XLEN         = 32;
  localparam int WAY_DEF      = 2;
  localparam int FQ_DEPTH_DEF = 8;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_MISS  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: up to WAY in-order writes at tail, up to WAY reads from head.
// Head entries are visible combinationally; flush empties it in one cycle.
module fetch_queue
  import fetch_pc_gen_pkg::*;
#(
  parameter int WAY   = WAY_DEF,
  parameter int DEPTH = FQ_DEPTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic [WAY-1:0]               enq_mask_i,
  input  fetch_pkt_t [WAY-1:0]         enq_pkt_i,
  input  logic [$clog2(WAY+1)-1:0]     deq_count_i,
  output fetch_pkt_t [WAY-1:0]         head_pkt_o,
  output logic [WAY-1:0]               head_vld_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(WAY+1);

  fetch_pkt_t      mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   enq_n;
  logic [DW-1:0]   slot_pos [WAY];

  // Kept slots are packed densely: each lands at tail + (number of kept slots before it).
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < WAY; i++) begin
      slot_pos[i] = enq_n;
      if (enq_mask_i[i]) enq_n = enq_n + DW'(1);
    end
  end

  always_comb begin
    head_d  = head_q + PW'(deq_count_i);
    tail_d  = tail_q + PW'(enq_n);
    count_d = count_q + CW'(enq_n) - CW'(deq_count_i);
  end

  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush_i) begin
      for (int i = 0; i < WAY; i++) begin
        if (enq_mask_i[i]) mem_q[tail_q + PW'(slot_pos[i])] <= enq_pkt_i[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      head_pkt_o[i] = mem_q[head_q + PW'(i)];
      head_vld_o[i] = (CW'(i) < count_q);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, looks up WAY slots in the predictor, truncates
// at the first predicted-taken slot and enqueues survivors; handles icache miss and redirect.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int              WAY      = WAY_DEF,
  parameter int              FQ_DEPTH = FQ_DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic [WAY-1:0]                  pc_find_valid,
  output logic [WAY-1:0][XLEN-1:0]        pc_find,
  input  logic [WAY-1:0]                  predict_result,
  input  logic [WAY-1:0][XLEN-1:0]        target_pc_in,
  output logic                            icache_req_valid,
  output logic [XLEN-1:0]                 icache_req_pc,
  input  logic                            icache_hit,
  input  logic [WAY-1:0][31:0]            icache_data,
  input  logic                            redirect_valid,
  input  logic [XLEN-1:0]                 redirect_pc,
  input  logic [$clog2(WAY+1)-1:0]        deq_count,
  output logic [WAY-1:0]                  out_valid,
  output logic [WAY-1:0][31:0]            out_inst,
  output logic [WAY-1:0][XLEN-1:0]        out_pc,
  output logic [WAY-1:0]                  out_pred_taken,
  output logic [WAY-1:0][XLEN-1:0]        out_pred_target,
  output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);

  localparam int CW = $clog2(FQ_DEPTH+1);
  localparam int DW = $clog2(WAY+1);

  fetch_state_e           state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [CW-1:0]          free;
  logic                   has_room;
  logic [WAY-1:0]         keep;
  logic [WAY-1:0]         enq_mask;
  logic [XLEN-1:0]        next_pc;
  logic [DW-1:0]          deq_eff;
  fetch_pkt_t [WAY-1:0]   enq_pkt;
  fetch_pkt_t [WAY-1:0]   head_pkt;

  // Room is judged on occupancy before this cycle's dequeue.
  assign free     = CW'(FQ_DEPTH) - fq_count;
  assign has_room = (free >= CW'(WAY));

  always_comb begin
    keep    = '0;
    keep[0] = 1'b1;
    for (int i = 1; i < WAY; i++) keep[i] = keep[i-1] & ~predict_result[i-1];
    next_pc = pc_q + XLEN'(4 * WAY);
    for (int i = WAY - 1; i >= 0; i--) begin
      if (predict_result[i]) next_pc = target_pc_in[i];
    end
    for (int i = 0; i < WAY; i++) begin
      pc_find[i]             = pc_q + XLEN'(4 * i);
      enq_pkt[i].inst        = icache_data[i];
      enq_pkt[i].pc          = pc_q + XLEN'(4 * i);
      enq_pkt[i].pred_taken  = predict_result[i];
      enq_pkt[i].pred_target = target_pc_in[i];
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    icache_req_valid = 1'b0;
    icache_req_pc    = pc_q;
    pc_find_valid    = '0;
    enq_mask         = '0;
    deq_eff          = deq_count;
    unique case (state_q)
      S_FETCH: begin
        if (has_room) begin
          icache_req_valid = 1'b1;
          pc_find_valid    = '1;
          if (!icache_hit) begin
            state_d = S_MISS;
          end else begin
            enq_mask = keep;
            pc_d     = next_pc;
          end
        end
      end
      S_MISS: begin
        icache_req_valid = 1'b1;
        if (icache_hit) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (redirect_valid) begin
      state_d  = S_FETCH;
      pc_d     = redirect_pc;
      enq_mask = '0;
      deq_eff  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(
    .WAY   (WAY),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .enq_mask_i  (enq_mask),
    .enq_pkt_i   (enq_pkt),
    .deq_count_i (deq_eff),
    .head_pkt_o  (head_pkt),
    .head_vld_o  (out_valid),
    .count_o     (fq_count)
  );

  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      out_inst[i]        = head_pkt[i].inst;
      out_pc[i]          = head_pkt[i].pc;
      out_pred_taken[i]  = head_pkt[i].pred_taken;
      out_pred_target[i] = head_pkt[i].pred_target;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed vector table, hand-written wrap/reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_fetch_pc_gen;

  localparam int W = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [W-1:0]      pc_find_valid;
  logic [W-1:0][31:0] pc_find;
  logic [W-1:0]      predict_result;
  logic [W-1:0][31:0] target_pc_in;
  logic              icache_req_valid;
  logic [31:0]       icache_req_pc;
  logic              icache_hit;
  logic [W-1:0][31:0] icache_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [1:0]        deq_count;
  logic [W-1:0]      out_valid;
  logic [W-1:0][31:0] out_inst;
  logic [W-1:0][31:0] out_pc;
  logic [W-1:0]      out_pred_taken;
  logic [W-1:0][31:0] out_pred_target;
  logic [3:0]        fq_count;

  fetch_pc_gen #(.WAY(2), .FQ_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_find_valid   (pc_find_valid),
    .pc_find         (pc_find),
    .predict_result  (predict_result),
    .target_pc_in    (target_pc_in),
    .icache_req_valid(icache_req_valid),
    .icache_req_pc   (icache_req_pc),
    .icache_hit      (icache_hit),
    .icache_data     (icache_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .deq_count       (deq_count),
    .out_valid       (out_valid),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .fq_count        (fq_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdr, input logic [31:0] rpc, input logic hit,
                       input logic [1:0] pr, input logic [31:0] t0, input logic [31:0] t1,
                       input logic [1:0] deq, input int cnt_now);
    int mx;
    mx = (cnt_now < 2) ? cnt_now : 2;
    assert (int'(deq) <= mx) else $fatal(1, "FAIL deq_bound: deq_count %0d exceeds %0d", deq, mx);
    redirect_valid  = rdr;
    redirect_pc     = rpc;
    icache_hit      = hit;
    predict_result  = pr;
    target_pc_in[0] = t0;
    target_pc_in[1] = t1;
    deq_count       = deq;
    icache_data[0]  = $urandom;
    icache_data[1]  = $urandom;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [1:0] vmask(input int cnt);
    return (cnt >= 2) ? 2'b11 : ((cnt == 1) ? 2'b01 : 2'b00);
  endfunction

  typedef struct {
    logic        rdr;
    logic [31:0] rpc;
    logic        hit;
    logic [1:0]  pr;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [1:0]  deq;
    int          e_cnt;
    logic [31:0] e_pc;
    logic [1:0]  e_pfv;
    logic [31:0] e_hpc;
    logic        e_htk;
    logic [31:0] e_htg;
  } vec_t;

  vec_t tbl[15];

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_miss;

  initial begin
    logic [31:0] exp_head;
    reset = 1'b1;

    // rdr rpc hit pr t0 t1 deq | cnt pc pfv head_pc head_tk head_tgt (after the edge)
    tbl[0]  = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 2, 32'h08,  2'b11, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 4, 32'h10,  2'b11, 32'h0,   1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 6, 32'h18,  2'b11, 32'h0,   1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 8, 32'h20,  2'b00, 32'h0,   1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 8, 32'h20,  2'b00, 32'h0,   1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd2, 6, 32'h20,  2'b11, 32'h8,   1'b0, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,   1'b0, 2'b00, 32'h0,   32'h0,   2'd0, 6, 32'h20,  2'b00, 32'h8,   1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 2'b00, 32'h0,   32'h0,   2'd0, 6, 32'h20,  2'b00, 32'h8,   1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,   1'b0, 2'b00, 32'h0,   32'h0,   2'd0, 6, 32'h20,  2'b00, 32'h8,   1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 6, 32'h20,  2'b11, 32'h8,   1'b0, 32'h0};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd0, 8, 32'h28,  2'b00, 32'h8,   1'b0, 32'h0};
    tbl[11] = '{1'b1, 32'h200, 1'b1, 2'b00, 32'h0,   32'h0,   2'd2, 0, 32'h200, 2'b11, 32'h0,   1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 2'b01, 32'h40,  32'h0,   2'd0, 1, 32'h40,  2'b11, 32'h200, 1'b1, 32'h40};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 2'b10, 32'h300, 32'h100, 2'd0, 3, 32'h100, 2'b11, 32'h200, 1'b1, 32'h40};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h0,   32'h0,   2'd2, 3, 32'h108, 2'b11, 32'h44,  1'b1, 32'h100};

    do_reset();
    chk("reset_count", 32'(fq_count), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_pc", icache_req_pc, 32'h0);
    chk("reset_pfv", 32'(pc_find_valid), 32'h3);
    chk("reset_req_vld", 32'(icache_req_valid), 32'd1);

    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].rdr, tbl[r].rpc, tbl[r].hit, tbl[r].pr, tbl[r].t0, tbl[r].t1, tbl[r].deq,
            (r == 0) ? 0 : tbl[r-1].e_cnt);
      tick();
      chk($sformatf("tbl%0d_count", r), 32'(fq_count), 32'(tbl[r].e_cnt));
      chk($sformatf("tbl%0d_pc", r), icache_req_pc, tbl[r].e_pc);
      chk($sformatf("tbl%0d_pfv", r), 32'(pc_find_valid), 32'(tbl[r].e_pfv));
      chk($sformatf("tbl%0d_valid", r), 32'(out_valid), 32'(vmask(tbl[r].e_cnt)));
      if (tbl[r].e_cnt > 0) begin
        chk($sformatf("tbl%0d_head_pc", r), out_pc[0], tbl[r].e_hpc);
        chk($sformatf("tbl%0d_head_tk", r), 32'(out_pred_taken[0]), 32'(tbl[r].e_htk));
        chk($sformatf("tbl%0d_head_tgt", r), out_pred_target[0], tbl[r].e_htg);
      end
      if (r >= 6 && r <= 8) chk($sformatf("tbl%0d_miss_req", r), 32'(icache_req_valid), 32'd1);
    end

    // Steady enqueue/dequeue of 2 per cycle across pointer wrap.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0, 2'd0, 2 * k);
      tick();
    end
    exp_head = 32'h0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0, 2'd2, 6);
      tick();
      exp_head = exp_head + 32'd8;
      chk($sformatf("wrap%0d_count", k), 32'(fq_count), 32'd6);
      chk($sformatf("wrap%0d_pc0", k), out_pc[0], exp_head);
      chk($sformatf("wrap%0d_pc1", k), out_pc[1], exp_head + 32'd4);
    end

    // Reset asserted while waiting on a miss with six entries queued.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b1, 2'b00, 32'h0, 32'h0, 2'd0, 2 * k);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0, 6);
    tick();
    chk("miss_pfv", 32'(pc_find_valid), 32'd0);
    chk("miss_count", 32'(fq_count), 32'd6);
    reset = 1'b1;
    drive(1'b1, 32'h500, 1'b0, 2'b00, 32'h0, 32'h0, 2'd0, 6);
    tick();
    reset = 1'b0;
    chk("rstmiss_count", 32'(fq_count), 32'd0);
    chk("rstmiss_pc", icache_req_pc, 32'h0);
    chk("rstmiss_pfv", 32'(pc_find_valid), 32'h3);
    chk("rstmiss_valid", 32'(out_valid), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_miss = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic        rdr, hit, room;
      logic [1:0]  pr;
      logic [31:0] rpc, t0, t1;
      logic [1:0]  deq;
      logic [31:0] d0, d1;
      int          mx;
      room = ((8 - mq.size()) >= 2);
      rdr  = ($urandom_range(0, 19) == 0);
      rpc  = 32'($urandom_range(0, 4095)) << 2;
      hit  = ($urandom_range(0, 3) != 0);
      pr[0] = ($urandom_range(0, 3) == 0);
      pr[1] = ($urandom_range(0, 3) == 0);
      t0   = 32'($urandom_range(0, 4095)) << 2;
      t1   = 32'($urandom_range(0, 4095)) << 2;
      mx   = (mq.size() < 2) ? mq.size() : 2;
      deq  = 2'($urandom_range(0, mx));
      drive(rdr, rpc, hit, pr, t0, t1, deq, mq.size());
      d0 = icache_data[0];
      d1 = icache_data[1];
      #3;
      chk("rnd_pfv", 32'(pc_find_valid), (!m_miss && room) ? 32'h3 : 32'h0);
      chk("rnd_req_vld", 32'(icache_req_valid), 32'(m_miss || room));
      chk("rnd_req_pc", icache_req_pc, m_pc);
      chk("rnd_pf1", pc_find[1], m_pc + 32'd4);
      chk("rnd_count", 32'(fq_count), 32'(mq.size()));
      for (int i = 0; i < 2; i++) begin
        chk("rnd_valid", 32'(out_valid[i]), 32'(i < mq.size()));
        if (i < mq.size()) begin
          chk("rnd_out_pc", out_pc[i], mq[i].pc);
          chk("rnd_out_inst", out_inst[i], mq[i].inst);
          chk("rnd_out_tk", 32'(out_pred_taken[i]), 32'(mq[i].tk));
          chk("rnd_out_tgt", out_pred_target[i], mq[i].tgt);
        end
      end
      @(posedge clock);
      if (rdr) begin
        mq.delete();
        m_pc   = rpc;
        m_miss = 1'b0;
      end else begin
        for (int i = 0; i < int'(deq); i++) void'(mq.pop_front());
        if (m_miss) begin
          if (hit) m_miss = 1'b0;
        end else if (room) begin
          if (!hit) begin
            m_miss = 1'b1;
          end else begin
            mq.push_back('{d0, m_pc, pr[0], t0});
            if (pr[0]) begin
              m_pc = t0;
            end else begin
              mq.push_back('{d1, m_pc + 32'd4, pr[1], t1});
              m_pc = pr[1] ? t1 : m_pc + 32'd8;
            end
          end
        end
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
